rf_wb_initiator: RTL and testbench
==================================

Name: rf_wb_initiator

Overview:
- Write-side initiator for the 32x32 register file: accepts writeback requests from execute/load sources, queues them in a small FIFO, and drives the register-file write port (we/addr/data) one write per cycle.
- Tracks pending destinations so decode can detect read-after-write hazards on rs1/rs2 before the register file is updated.
- Sits between the writeback mux and the register-file write port; honours a stall from the port owner.

Parameters:
N, 32, data width of register values
DEPTH, 4, FIFO entries (power of two, >=2)
AW, 5, register address width

Ports:
clk  in  1  clock
rst  in  1  reset
flush  in  1  synchronous drop of all queued (not in-flight) writes
req_valid  in  1  writeback request present
req_ready  out  1  request accepted when valid&ready at rising edge
req_rd  in  AW  destination register
req_data  in  N  write value
rf_stall  in  1  write port unavailable this cycle
rf_we  out  1  register-file write enable (registered)
rf_waddr  out  AW  write address (registered)
rf_wdata  out  N  write data (registered)
chk_rs1  in  AW  decode source 1
chk_rs2  in  AW  decode source 2
busy_rs1  out  1  pending write to chk_rs1
busy_rs2  out  1  pending write to chk_rs2

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk, all state on posedge clk. Reset clears FIFO, count=0, state=IDLE, rf_we=0, rf_waddr=0, rf_wdata=0. req_ready=0 and busy_rs*=0 while rst is high.
- req_ready = !rst & (count != DEPTH); combinational. No push when full, even if a pop happens the same cycle.
- Accepted request with req_rd==0 is consumed (handshake completes) but not enqueued; x0 is never written.
- FSM: IDLE (count==0), DRAIN (count>0, !rf_stall), HOLD (count>0, rf_stall).
  - IDLE->DRAIN on push.
  - DRAIN->HOLD when rf_stall=1.
  - HOLD->DRAIN when rf_stall=0.
  - DRAIN->IDLE when last entry pops with no push.
  - Any state->IDLE on flush.
- Pop: in DRAIN with rf_stall=0, the head entry is popped at the edge, and rf_we<=1, rf_waddr<=head.rd, rf_wdata<=head.data. Otherwise rf_we<=0 and rf_waddr/rf_wdata hold.
- Latency: request accepted at edge k; rf_we high in the cycle after edge k+1 if the queue was empty and not stalled. Throughput 1 write/cycle sustained.
- rf_stall seen in the same cycle as a would-be pop blocks the pop; entry and order are preserved.
- Simultaneous push and pop (not full): count unchanged, both happen.
- Pointers wrap modulo DEPTH; count is 0..DEPTH inclusive, AW-independent width clog2(DEPTH)+1.
- flush: count<=0, pointers<=0, rf_we<=0. Flush beats a same-cycle push (request is consumed and dropped). A write already on rf_we that cycle still completes.
- busy_rsX = (chk_rsX != 0) & (match in any valid FIFO entry, or rf_we & rf_waddr==chk_rsX). Combinational from registered state; in-flight write counts as busy because the register file updates at the next edge.
- Order: writes to the same rd are issued strictly in acceptance order.

Optional Feature:
- Macro: RF_WB_FWD_EN.
- Defined: adds outputs fwd_data1/fwd_data2 (N bits). Each carries the data of the youngest pending write matching chk_rsX. Priority, youngest first: FIFO tail-1 back to head, then the in-flight rf_wdata. The output is 0 when busy_rsX=0.
- Undefined: ports and match-priority logic are absent; only busy flags are provided.

Test Plan:
1. Reset mid-drain: 3 entries queued, assert rst -> rf_we=0, req_ready=0 during rst, count=0 after; next request rd=5 data=0xA5 appears on rf_we two cycles after accept.
2. Single write: rd=7, data=0xDEADBEEF into an empty queue -> rf_we=1 exactly one cycle, rf_waddr=7, rf_wdata=0xDEADBEEF. busy_rs1 (chk_rs1=7) is high from the cycle after accept through the rf_we cycle, then 0.
3. Fill/stall: hold rf_stall=1, push 4 requests -> req_ready=0 after 4th. A 5th held valid is accepted only after stall drops. Writes emerge in order rd=1,2,3,4 on consecutive cycles.
4. x0 discard: push rd=0 data=0x1234 -> handshake completes, no rf_we, busy_rs1 with chk_rs1=0 stays 0.
5. Flush: 3 queued (rd=3,4,5), flush while rd=3 is on rf_we -> rd=3 write completes, rd=4/5 never written, busy flags for 4/5 clear next cycle.
6. (RF_WB_FWD_EN) queue rd=9 data=1 then rd=9 data=2, chk_rs1=9 -> fwd_data1=2, busy_rs1=1; after first pops, still 2.

Source files
------------

// File: rtl/rf_wb_initiator.sv
// ---------------------------------------------------------------------------
// rf_wb_initiator
//   Write-side initiator for the 32x32 register file. Writeback requests from
//   the execute/load sources are queued in a small FIFO and drained onto the
//   register-file write port at one write per cycle, honouring a stall from
//   the port owner. Pending destinations (queued or in flight) are reported
//   to decode so read-after-write hazards on rs1/rs2 can be detected before
//   the register file is updated.
//
//   Optional feature macro: RF_WB_FWD_EN
//     When defined, fwd_data1/fwd_data2 carry the data of the youngest
//     pending write to chk_rs1/chk_rs2 (0 when nothing is pending).
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   flush           drop every queued (not in-flight) write
//   req_valid/ready request handshake; req_rd/req_data destination and value
//   rf_stall        write port unavailable this cycle
//   rf_we/waddr/wdata  registered register-file write port
//   chk_rs1/2       decode source registers to check
//   busy_rs1/2      a write to chk_rsX is still pending
//   fwd_data1/2     (RF_WB_FWD_EN) youngest pending value for chk_rsX
// ---------------------------------------------------------------------------
module rf_wb_initiator #(
    parameter int N     = 32,
    parameter int DEPTH = 4,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [AW-1:0] req_rd,
    input  logic [N-1:0]  req_data,
    input  logic          rf_stall,
    output logic          rf_we,
    output logic [AW-1:0] rf_waddr,
    output logic [N-1:0]  rf_wdata,
    input  logic [AW-1:0] chk_rs1,
    input  logic [AW-1:0] chk_rs2,
    output logic          busy_rs1,
    output logic          busy_rs2
`ifdef RF_WB_FWD_EN
    ,
    output logic [N-1:0]  fwd_data1,
    output logic [N-1:0]  fwd_data2
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, DRAIN, HOLD} state_t;

    typedef struct packed {
        logic [AW-1:0] rd;
        logic [N-1:0]  data;
    } entry_t;

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    entry_t        mem_q [DEPTH];
    entry_t        mem_d [DEPTH];
    logic          rf_we_q, rf_we_d;
    logic [AW-1:0] rf_waddr_q, rf_waddr_d;
    logic [N-1:0]  rf_wdata_q, rf_wdata_d;

    logic push;
    logic pop;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before any branch so no path can
        // leave it unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        mem_d      = mem_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;

        req_ready = !rst && (count_q != FULL);

        // x0 requests complete the handshake but are never queued; a flush
        // drops a same-cycle request as well.
        push = req_valid && req_ready && (req_rd != '0) && !flush;
        // Only DRAIN pops: leaving HOLD costs one cycle to re-enter DRAIN.
        pop  = (state_q == DRAIN) && !rf_stall && !flush;

        if (push) begin
            mem_d[wr_ptr_q] = '{rd: req_rd, data: req_data};
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end

        if (pop) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = mem_q[rd_ptr_q].rd;
            rf_wdata_d = mem_q[rd_ptr_q].data;
            rd_ptr_d   = rd_ptr_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        case (state_q)
            IDLE:    if (push) state_d = DRAIN;
            DRAIN: begin
                if (rf_stall)            state_d = HOLD;
                else if (count_d == '0)  state_d = IDLE;
            end
            HOLD:    if (!rf_stall) state_d = DRAIN;
            default: state_d = IDLE;
        endcase

        // Queued writes are discarded; the write already on the port (held
        // in rf_*_q this cycle) still lands at the coming edge.
        if (flush) begin
            state_d  = IDLE;
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    // NOTE: the entry storage has no reset; count and pointers define which
    // slots are valid, so stale contents are never observed.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;

    // -----------------------------------------------------------------------
    // Hazard lookup: queued entries plus the in-flight write, since the
    // register file only takes the in-flight value at the next edge.
    // -----------------------------------------------------------------------
    function automatic logic pending_hit(input logic [AW-1:0] rs);
        logic hit;
        hit = rf_we_q && (rf_waddr_q == rs);
        for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < count_q) && (mem_q[rd_ptr_q + PW'(i)].rd == rs)) begin
                hit = 1'b1;
            end
        end
        return hit && (rs != '0) && !rst;
    endfunction

    always_comb begin
        busy_rs1 = pending_hit(chk_rs1);
        busy_rs2 = pending_hit(chk_rs2);
    end

`ifdef RF_WB_FWD_EN
    // Walk from oldest (in-flight, then head) to youngest (tail-1); the last
    // match overwrites earlier ones, so the youngest write wins.
    function automatic logic [N-1:0] youngest_data(input logic [AW-1:0] rs);
        logic [N-1:0] data;
        data = (rf_we_q && (rf_waddr_q == rs)) ? rf_wdata_q : '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < count_q) && (mem_q[rd_ptr_q + PW'(i)].rd == rs)) begin
                data = mem_q[rd_ptr_q + PW'(i)].data;
            end
        end
        return ((rs != '0) && !rst) ? data : '0;
    endfunction

    always_comb begin
        fwd_data1 = youngest_data(chk_rs1);
        fwd_data2 = youngest_data(chk_rs2);
    end
`endif

endmodule

// File: tb/tb_rf_wb_initiator.sv
// ---------------------------------------------------------------------------
// tb_rf_wb_initiator
//   Self-checking bench for rf_wb_initiator: reset behaviour, a table of
//   cycle vectors (single write, x0 discard, flush), hand-written fill/stall
//   and forwarding sequences, then randomized traffic against a queue model.
// ---------------------------------------------------------------------------
module tb_rf_wb_initiator;

    localparam int N     = 32;
    localparam int DEPTH = 4;
    localparam int AW    = 5;

    logic          clk;
    logic          rst;
    logic          flush;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_rd;
    logic [N-1:0]  req_data;
    logic          rf_stall;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [N-1:0]  rf_wdata;
    logic [AW-1:0] chk_rs1;
    logic [AW-1:0] chk_rs2;
    logic          busy_rs1;
    logic          busy_rs2;
`ifdef RF_WB_FWD_EN
    logic [N-1:0]  fwd_data1;
    logic [N-1:0]  fwd_data2;
`endif

    rf_wb_initiator #(.N(N), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_rd    (req_rd),
        .req_data  (req_data),
        .rf_stall  (rf_stall),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .chk_rs1   (chk_rs1),
        .chk_rs2   (chk_rs2),
        .busy_rs1  (busy_rs1),
        .busy_rs2  (busy_rs2)
`ifdef RF_WB_FWD_EN
        ,
        .fwd_data1 (fwd_data1),
        .fwd_data2 (fwd_data2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------------------------------------------------------------
    // Vector table: inputs for one cycle and the outputs expected in that
    // cycle (sampled mid-cycle, before the edge that consumes the inputs).
    // ---------------------------------------------------------------------
    typedef struct {
        int          valid;
        int          rd;
        logic [31:0] data;
        int          stall;
        int          flush;
        int          c1;
        int          c2;
        int          e_ready;
        int          e_we;
        int          e_waddr;
        logic [31:0] e_wdata;
        int          e_b1;
        int          e_b2;
    } vec_t;

    vec_t vecs [15];

    // ---------------------------------------------------------------------
    // Reference model: the queue contents in acceptance order, the write
    // presented on the port, and whether a stall with pending entries was
    // seen last cycle (which costs one recovery cycle before draining).
    // ---------------------------------------------------------------------
    typedef struct {
        logic [AW-1:0] rd;
        logic [N-1:0]  data;
    } ent_t;

    ent_t          mq[$];
    logic          m_we;
    logic [AW-1:0] m_waddr;
    logic [N-1:0]  m_wdata;
    logic          m_stalled;

    task automatic model_reset();
        mq.delete();
        m_we      = 1'b0;
        m_waddr   = '0;
        m_wdata   = '0;
        m_stalled = 1'b0;
    endtask

    function automatic logic m_busy(input logic [AW-1:0] r);
        if (r == 0) return 1'b0;
        if (m_we && m_waddr == r) return 1'b1;
        foreach (mq[j]) if (mq[j].rd == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [N-1:0] m_fwd(input logic [AW-1:0] r);
        if (r == 0) return '0;
        for (int j = mq.size() - 1; j >= 0; j--) if (mq[j].rd == r) return mq[j].data;
        if (m_we && m_waddr == r) return m_wdata;
        return '0;
    endfunction

    // Apply the effect of one rising edge using the inputs held this cycle.
    task automatic model_edge();
        int   sz;
        logic can_pop;
        logic acc;
        ent_t e;
        sz        = mq.size();
        can_pop   = (sz > 0) && !rf_stall && !m_stalled && !flush;
        acc       = req_valid && (sz < DEPTH);
        m_stalled = (sz > 0) && rf_stall && !flush;
        if (flush) begin
            mq.delete();
            m_we = 1'b0;
        end else begin
            if (can_pop) begin
                e       = mq.pop_front();
                m_we    = 1'b1;
                m_waddr = e.rd;
                m_wdata = e.data;
            end else begin
                m_we = 1'b0;
            end
            if (acc && req_rd != 0) mq.push_back('{rd: req_rd, data: req_data});
        end
    endtask

    initial begin
        logic [AW-1:0] wq[$];
        int            wc[$];
        logic          acc;
        logic          acc5;
        int            guard;

        rst       = 1'b1;
        flush     = 1'b0;
        req_valid = 1'b0;
        req_rd    = '0;
        req_data  = '0;
        rf_stall  = 1'b0;
        chk_rs1   = '0;
        chk_rs2   = '0;

        //           vld rd data          stl fl c1 c2  rdy we wa wdata        b1 b2
        // single write rd=7
        vecs[0]  = '{1, 7, 32'hDEADBEEF, 0, 0, 7, 0,  1, 0, 0, 0,            0, 0};
        vecs[1]  = '{0, 0, 0,            0, 0, 7, 0,  1, 0, 0, 0,            1, 0};
        vecs[2]  = '{0, 0, 0,            0, 0, 7, 0,  1, 1, 7, 32'hDEADBEEF, 1, 0};
        vecs[3]  = '{0, 0, 0,            0, 0, 7, 0,  1, 0, 0, 0,            0, 0};
        // x0 discard
        vecs[4]  = '{1, 0, 32'h1234,     0, 0, 0, 0,  1, 0, 0, 0,            0, 0};
        vecs[5]  = '{0, 0, 0,            0, 0, 0, 0,  1, 0, 0, 0,            0, 0};
        vecs[6]  = '{0, 0, 0,            0, 0, 0, 0,  1, 0, 0, 0,            0, 0};
        // flush with rd=3 in flight, rd=4/5 queued
        vecs[7]  = '{1, 3, 32'h33,       1, 0, 4, 5,  1, 0, 0, 0,            0, 0};
        vecs[8]  = '{1, 4, 32'h44,       1, 0, 4, 5,  1, 0, 0, 0,            0, 0};
        vecs[9]  = '{1, 5, 32'h55,       1, 0, 4, 5,  1, 0, 0, 0,            1, 0};
        vecs[10] = '{0, 0, 0,            0, 0, 4, 5,  1, 0, 0, 0,            1, 1};
        vecs[11] = '{0, 0, 0,            0, 0, 4, 5,  1, 0, 0, 0,            1, 1};
        vecs[12] = '{0, 0, 0,            0, 1, 4, 5,  1, 1, 3, 32'h33,       1, 1};
        vecs[13] = '{0, 0, 0,            0, 0, 4, 5,  1, 0, 0, 0,            0, 0};
        vecs[14] = '{0, 0, 0,            0, 0, 4, 5,  1, 0, 0, 0,            0, 0};

        // ---------------- initial reset ----------------
        req_valid = 1'b1;
        req_rd    = 5'd9;
        tick();
        check("rst ready", 32'(req_ready), 0);
        check("rst we", 32'(rf_we), 0);
        check("rst waddr", 32'(rf_waddr), 0);
        check("rst wdata", rf_wdata, 0);
        tick();
        rst       = 1'b0;
        req_valid = 1'b0;
        #3;
        check("post rst ready", 32'(req_ready), 1);

        // ---------------- reset mid-drain ----------------
        tick();
        rf_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1;
            req_rd    = AW'(10 + i);
            req_data  = 32'(i);
            tick();
        end
        req_valid = 1'b0;
        rf_stall  = 1'b0;
        tick();
        tick();
        check("t1 we before rst", 32'(rf_we), 1);
        chk_rs1   = 5'd11;
        req_valid = 1'b1;
        req_rd    = 5'd6;
        rst       = 1'b1;
        #1;
        check("t1 we in rst", 32'(rf_we), 0);
        check("t1 ready in rst", 32'(req_ready), 0);
        check("t1 busy in rst", 32'(busy_rs1), 0);
        tick();
        check("t1 ready in rst2", 32'(req_ready), 0);
        rst       = 1'b0;
        req_valid = 1'b0;
        #3;
        check("t1 ready after rst", 32'(req_ready), 1);
        check("t1 busy after rst", 32'(busy_rs1), 0);
        check("t1 we after rst", 32'(rf_we), 0);
        tick();
        req_valid = 1'b1;
        req_rd    = 5'd5;
        req_data  = 32'hA5;
        #3;
        check("t1 ready accept", 32'(req_ready), 1);
        tick();
        req_valid = 1'b0;
        #3;
        check("t1 we +1", 32'(rf_we), 0);
        tick();
        #2;
        check("t1 we +2", 32'(rf_we), 1);
        check("t1 waddr +2", 32'(rf_waddr), 5);
        check("t1 wdata +2", rf_wdata, 32'hA5);
        tick();
        check("t1 we +3", 32'(rf_we), 0);
        chk_rs1 = '0;

        // ---------------- vector table ----------------
        foreach (vecs[i]) begin
            req_valid = vecs[i].valid[0];
            req_rd    = AW'(vecs[i].rd);
            req_data  = vecs[i].data;
            rf_stall  = vecs[i].stall[0];
            flush     = vecs[i].flush[0];
            chk_rs1   = AW'(vecs[i].c1);
            chk_rs2   = AW'(vecs[i].c2);
            #3;
            check($sformatf("vec%0d ready", i), 32'(req_ready), 32'(vecs[i].e_ready));
            check($sformatf("vec%0d we", i), 32'(rf_we), 32'(vecs[i].e_we));
            if (vecs[i].e_we != 0) begin
                check($sformatf("vec%0d waddr", i), 32'(rf_waddr), 32'(vecs[i].e_waddr));
                check($sformatf("vec%0d wdata", i), rf_wdata, vecs[i].e_wdata);
            end
            check($sformatf("vec%0d busy1", i), 32'(busy_rs1), 32'(vecs[i].e_b1));
            check($sformatf("vec%0d busy2", i), 32'(busy_rs2), 32'(vecs[i].e_b2));
            tick();
        end
        req_valid = 1'b0;
        flush     = 1'b0;
        chk_rs1   = '0;
        chk_rs2   = '0;

        // ---------------- fill under stall, then drain ----------------
        rf_stall = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            req_valid = 1'b1;
            req_rd    = AW'(i);
            req_data  = 32'h100 + 32'(i);
            #3;
            check($sformatf("t3 ready push%0d", i), 32'(req_ready), 1);
            tick();
        end
        req_rd   = 5'd5;
        req_data = 32'h105;
        for (int i = 0; i < 3; i++) begin
            #3;
            check($sformatf("t3 full ready%0d", i), 32'(req_ready), 0);
            tick();
        end
        rf_stall = 1'b0;
        acc5     = 1'b0;
        for (int c = 0; c < 12; c++) begin
            #3;
            if (rf_we) begin
                wq.push_back(rf_waddr);
                wc.push_back(c);
            end
            acc = req_valid && req_ready;
            tick();
            if (acc) begin
                req_valid = 1'b0;
                acc5      = 1'b1;
            end
        end
        req_valid = 1'b0;
        check("t3 fifth accepted", 32'(acc5), 1);
        check("t3 write count", 32'(wq.size()), 5);
        for (int k = 0; k < wq.size() && k < 5; k++) begin
            check($sformatf("t3 order%0d", k), 32'(wq[k]), 32'(k + 1));
            check($sformatf("t3 back2back%0d", k), 32'(wc[k]), 32'(wc[0] + k));
        end

`ifdef RF_WB_FWD_EN
        // ---------------- forwarding youngest value ----------------
        rf_stall  = 1'b1;
        chk_rs1   = 5'd9;
        chk_rs2   = 5'd0;
        req_valid = 1'b1;
        req_rd    = 5'd9;
        req_data  = 32'd1;
        tick();
        req_data  = 32'd2;
        tick();
        req_valid = 1'b0;
        #3;
        check("t6 fwd queued", fwd_data1, 2);
        check("t6 busy queued", 32'(busy_rs1), 1);
        check("t6 fwd2 x0", fwd_data2, 0);
        tick();
        rf_stall = 1'b0;
        guard    = 0;
        #3;
        while (!rf_we && guard < 8) begin
            tick();
            #3;
            guard++;
        end
        check("t6 first write", rf_wdata, 1);
        check("t6 fwd after pop", fwd_data1, 2);
        check("t6 busy after pop", 32'(busy_rs1), 1);
        tick();
        #3;
        check("t6 second write", rf_wdata, 2);
        check("t6 fwd in flight", fwd_data1, 2);
        tick();
        #3;
        check("t6 fwd clear", fwd_data1, 0);
        check("t6 busy clear", 32'(busy_rs1), 0);
        tick();
        chk_rs1 = '0;
`endif

        // ---------------- randomized traffic vs model ----------------
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        for (int c = 0; c < 600; c++) begin
            req_valid = ($urandom_range(0, 9) < 6);
            req_rd    = AW'($urandom_range(0, 7));
            req_data  = $urandom;
            rf_stall  = ($urandom_range(0, 9) < 3);
            flush     = ($urandom_range(0, 99) < 3);
            chk_rs1   = AW'($urandom_range(0, 7));
            chk_rs2   = AW'($urandom_range(0, 7));
            #3;
            check($sformatf("rnd%0d ready", c), 32'(req_ready), 32'(mq.size() < DEPTH));
            check($sformatf("rnd%0d we", c), 32'(rf_we), 32'(m_we));
            check($sformatf("rnd%0d waddr", c), 32'(rf_waddr), 32'(m_waddr));
            check($sformatf("rnd%0d wdata", c), rf_wdata, m_wdata);
            check($sformatf("rnd%0d busy1", c), 32'(busy_rs1), 32'(m_busy(chk_rs1)));
            check($sformatf("rnd%0d busy2", c), 32'(busy_rs2), 32'(m_busy(chk_rs2)));
`ifdef RF_WB_FWD_EN
            check($sformatf("rnd%0d fwd1", c), fwd_data1, m_fwd(chk_rs1));
            check($sformatf("rnd%0d fwd2", c), fwd_data2, m_fwd(chk_rs2));
`endif
            @(posedge clk);
            model_edge();
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
